// File: rtl/execute_cycle.sv
// execute_cycle: execute stage of the pipelined RV32I core.
// Selects forwarded operands, runs the 32-bit ALU, resolves beq-style
// branches, computes the branch target and registers the EX/MEM results.
// Optional feature macro: FORWARDING_EN. When defined, ForwardA_E and
// ForwardB_E steer the operand muxes. When undefined, the operands come
// straight from decode and the forwarding inputs are ignored.
module execute_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        ALUSrcE,
    input  logic        MemWriteE,
    input  logic        ResultSrcE,
    input  logic        BranchE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [4:0]  RD_E,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    input  logic [31:0] ResultW,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM,
    output logic [31:0] PCPlus4M
);

    // EX/MEM pipeline register state
    logic        reg_write_q, mem_write_q, result_src_q;
    logic [4:0]  rd_q;
    logic [31:0] alu_result_q, write_data_q, pc_plus4_q;

    logic        [31:0] src_a, fwd_b, src_b;
    logic signed [31:0] src_a_s, src_b_s;
    logic        [31:0] alu_result_d;
    logic               zero_e;

    // 3:1 forwarding mux; code 11 is unused by the hazard unit and falls back to the register file
    function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] rf,
                                            input logic [31:0] wb, input logic [31:0] mem);
        case (sel)
            2'b01:   fwd_sel = wb;
            2'b10:   fwd_sel = mem;
            default: fwd_sel = rf;
        endcase
    endfunction

    // 32-bit ALU; add/sub wrap, slt compares as two's complement, spare codes yield zero
    function automatic logic [31:0] alu_op(input logic [2:0] ctl, input logic signed [31:0] a,
                                           input logic signed [31:0] b);
        case (ctl)
            3'b000:  alu_op = 32'(a + b);
            3'b001:  alu_op = 32'(a - b);
            3'b010:  alu_op = 32'(a & b);
            3'b011:  alu_op = 32'(a | b);
            3'b101:  alu_op = (a < b) ? 32'h1 : 32'h0;
            default: alu_op = 32'h0;
        endcase
    endfunction

`ifdef FORWARDING_EN
    assign src_a = fwd_sel(ForwardA_E, RD1_E, ResultW, alu_result_q);
    assign fwd_b = fwd_sel(ForwardB_E, RD2_E, ResultW, alu_result_q);
`else
    // Forwarding inputs are kept on the port list for a uniform interface but have no effect here
    logic unused_fwd;
    assign unused_fwd = ^{ForwardA_E, ForwardB_E, ResultW};
    assign src_a = RD1_E;
    assign fwd_b = RD2_E;
`endif

    assign src_b        = ALUSrcE ? Imm_Ext_E : fwd_b;
    assign src_a_s      = $signed(src_a);
    assign src_b_s      = $signed(src_b);
    assign alu_result_d = alu_op(ALUControlE, src_a_s, src_b_s);
    assign zero_e       = (alu_result_d == 32'h0);

    // Branch decision is suppressed while reset is held; the target stays live
    assign PCSrcE    = rst & BranchE & zero_e;
    assign PCTargetE = PCE + Imm_Ext_E;

    // EX/MEM capture every clock; asynchronous clear of all fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            rd_q         <= 5'd0;
            alu_result_q <= 32'h0;
            write_data_q <= 32'h0;
            pc_plus4_q   <= 32'h0;
        end else begin
            reg_write_q  <= RegWriteE;
            mem_write_q  <= MemWriteE;
            result_src_q <= ResultSrcE;
            rd_q         <= RD_E;
            alu_result_q <= alu_result_d;
            write_data_q <= fwd_b;
            pc_plus4_q   <= PCPlus4E;
        end
    end

    assign RegWriteM  = reg_write_q;
    assign MemWriteM  = mem_write_q;
    assign ResultSrcM = result_src_q;
    assign RD_M       = rd_q;
    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign PCPlus4M   = pc_plus4_q;

endmodule

// File: doc/execute_cycle.md
# execute_cycle

Execute stage of the pipelined RV32I core; sits directly downstream of the decode stage and consumes its registered E-stage outputs. Selects forwarded operands, runs the 32-bit ALU, resolves branches and computes the branch target. Registers the results into the EX/MEM pipeline register that drives the memory stage.

## Interface
- No parameters; datapath fixed at 32 bits, register index at 5 bits.
- clk  in  1  pipeline clock, rising-edge.
- rst  in  1  asynchronous, active-low reset; 0 clears all EX/MEM registers.
- RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  in  1 each  control bits from decode.
- ALUControlE  in  3  ALU operation select.
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  32 each  operands, immediate, PC, PC+4 from decode.
- RD_E  in  5  destination register index.
- ForwardA_E, ForwardB_E  in  2 each  forwarding selects from the hazard unit.
- ResultW  in  32  writeback-stage result, for forwarding.
- PCSrcE  out  1  branch taken; combinational, to fetch.
- PCTargetE  out  32  branch target; combinational, to fetch.
- RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered control bits.
- RD_M  out  5  registered destination index.
- ALUResultM, WriteDataM, PCPlus4M  out  32 each  registered datapath values.

## Operation
- SrcA: ForwardA_E 00 -> RD1_E, 01 -> ResultW, 10 -> ALUResultM, 11 -> RD1_E.
- Forwarded B: same encoding on ForwardB_E over RD2_E.
- SrcB = ALUSrcE ? Imm_Ext_E : forwarded B.
- ALUControlE: 000 add, 001 sub, 010 and, 011 or, 101 signed set-less-than (result 32'h1 or 32'h0). Codes 100, 110 and 111 produce 32'h0.
- add/sub wrap modulo 2^32; no carry or overflow outputs.
- ZeroE = (ALU result == 0).
- PCSrcE = BranchE & ZeroE (beq semantics).
- PCTargetE = PCE + Imm_Ext_E, wrapping modulo 2^32.
- WriteDataM captures the forwarded B value, not SrcB.
- EX/MEM register captures RegWriteE, MemWriteE, ResultSrcE, RD_E, PCPlus4E, the ALU result and forwarded B every clock; there is no stall or flush input.

## Timing
- ALU, forwarding muxes, PCSrcE and PCTargetE are combinational within the E cycle.
- All M outputs appear exactly one cycle after their E inputs.
- Forwarding path 10 uses the current ALUResultM register, giving a back-to-back dependency zero extra latency.
- Reset value of every M output is 0: RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M.
- While rst = 0, PCSrcE is forced to 0. PCTargetE remains combinational.
- Reset asserted mid-operation clears the M registers immediately and asynchronously. The first capture occurs on the first rising clk edge after rst returns to 1.
- Forwarding path 10 uses the register value current at that time, which is 0 while the register is held in reset.

## Configuration
- FORWARDING_EN defined: ForwardA_E and ForwardB_E are honored as described in Operation.
- FORWARDING_EN undefined: ForwardA_E and ForwardB_E are ignored. SrcA = RD1_E and forwarded B = RD2_E; the hazard unit must stall instead.
- Port list is identical in both builds.

## Test plan
- Reset: drive rst = 0 with nonzero inputs -> all M outputs 0 and PCSrcE = 0; release rst -> values captured on the next edge.
- Add with immediate: RD1_E = 5, Imm_Ext_E = 7, ALUSrcE = 1, ALUControlE = 000 -> next cycle ALUResultM = 12.
- Sub wrap and slt:
  - 0 − 1 -> ALUResultM = 32'hFFFFFFFF.
  - slt with SrcA = 32'hFFFFFFFF, SrcB = 1 -> ALUResultM = 1.
- Branch: BranchE = 1, RD1_E = RD2_E = 9, ALUControlE = 001, PCE = 32'h100, Imm_Ext_E = 32'h10 -> PCSrcE = 1 and PCTargetE = 32'h110 in the same cycle. With RD2_E = 8 -> PCSrcE = 0.
- Forwarding (FORWARDING_EN):
  - ALUResultM = 20, ForwardA_E = 10, RD1_E = 0, SrcB = 1 (add) -> ALUResultM = 21.
  - ForwardB_E = 01, ResultW = 32'hAB, MemWriteE = 1 -> WriteDataM = 32'hAB.
- Without FORWARDING_EN: same forwarding stimulus -> ALUResultM = 1 and WriteDataM = RD2_E.
